// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product operand loader.
//   N            elements per dot product (multiple of LANES)
//   WEIGHT_WIDTH signed weight element width
//   ACT_WIDTH    signed activation element width
//   LANES        element pairs per input beat
//   BEATS        beats per operand frame (N / LANES)
//   RESULT_WIDTH engine result width
//   TIMEOUT      WAIT cycles allowed for the engine's done strobe
package dot_pkg;

  localparam int N            = 128;
  localparam int WEIGHT_WIDTH = 4;
  localparam int ACT_WIDTH    = 4;
  localparam int LANES        = 8;
  localparam int BEATS        = N / LANES;
  localparam int RESULT_WIDTH = 16;
  localparam int TIMEOUT      = 15;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/dot_beat_packer.sv
// Beat counter and operand assembly for the dot-product loader.
// Each accepted beat k writes its LANES weight/activation pairs into elements
// k*LANES .. k*LANES+LANES-1 of the flat operand registers.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   wr_en         accepted beat: write lanes and advance the beat count
//   clr           return the beat count to 0 (frame abort)
//   beat_w/beat_a lane-packed weights / activations of the current beat
//   last_beat     the beat count points at the final beat of a frame
//   beat_done     the final beat of a frame is being accepted this cycle
//   weights_flat  assembled weight vector
//   acts_flat     assembled activation vector
module dot_beat_packer
  import dot_pkg::*;
#(
  parameter int N            = dot_pkg::N,
  parameter int WEIGHT_WIDTH = dot_pkg::WEIGHT_WIDTH,
  parameter int ACT_WIDTH    = dot_pkg::ACT_WIDTH,
  parameter int LANES        = dot_pkg::LANES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          clr,
  input  logic [LANES*WEIGHT_WIDTH-1:0] beat_w,
  input  logic [LANES*ACT_WIDTH-1:0]    beat_a,
  output logic                          last_beat,
  output logic                          beat_done,
  output logic [N*WEIGHT_WIDTH-1:0]     weights_flat,
  output logic [N*ACT_WIDTH-1:0]        acts_flat
);

  localparam int NBEATS = N / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [CNT_W-1:0] beat_cnt;

  assign last_beat = (beat_cnt == CNT_W'(NBEATS - 1));
  assign beat_done = wr_en & last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
    end else if (wr_en) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Element index of lane j is beat_cnt*LANES + j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights_flat <= '0;
      acts_flat    <= '0;
    end else if (wr_en) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        weights_flat[(32'(beat_cnt) * LANES + j) * WEIGHT_WIDTH +: WEIGHT_WIDTH]
          <= beat_w[j * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        acts_flat[(32'(beat_cnt) * LANES + j) * ACT_WIDTH +: ACT_WIDTH]
          <= beat_a[j * ACT_WIDTH +: ACT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/dot_operand_loader.sv
// Initiator-side front end for the pipelined signed dot-product engine.
// Assembles operand vectors from valid/ready beats, issues a one-cycle start,
// holds the operands while the engine runs, and returns the engine result on
// a valid/ready output. One dot product in flight at a time.
// Ports:
//   clk, rst_n                   clock / asynchronous active-low reset
//   in_valid/in_ready            operand beat handshake
//   in_w, in_a, in_last          lane-packed weights/activations, frame end
//   o_start                      one-cycle start pulse to the engine
//   o_weights_flat, o_acts_flat  assembled operands to the engine
//   i_done, i_result             engine result strobe and value
//   res_valid/res_ready/res_data result handshake and captured result
//   err_len, err_timeout         sticky framing / engine-timeout errors
//   err_clr                      clears both sticky errors (a new error wins)
module dot_operand_loader
  import dot_pkg::*;
#(
  parameter int N            = dot_pkg::N,
  parameter int WEIGHT_WIDTH = dot_pkg::WEIGHT_WIDTH,
  parameter int ACT_WIDTH    = dot_pkg::ACT_WIDTH,
  parameter int LANES        = dot_pkg::LANES,
  parameter int TIMEOUT      = dot_pkg::TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0] in_w,
  input  logic [LANES*ACT_WIDTH-1:0]    in_a,
  input  logic                          in_last,
  output logic                          o_start,
  output logic [N*WEIGHT_WIDTH-1:0]     o_weights_flat,
  output logic [N*ACT_WIDTH-1:0]        o_acts_flat,
  input  logic                          i_done,
  input  logic [RESULT_WIDTH-1:0]       i_result,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [RESULT_WIDTH-1:0]       res_data,
  output logic                          err_len,
  output logic                          err_timeout,
  input  logic                          err_clr
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             beat_fire;
  logic             last_beat;
  logic             beat_done;
  logic             early_last;
  logic             len_err;
  logic             tmo_hit;

  assign beat_fire  = in_valid & in_ready;
  assign early_last = beat_fire & in_last & ~last_beat;
  // Early in_last aborts the frame; a missing in_last still completes it.
  assign len_err    = early_last | (beat_done & ~in_last);
  // Fires on the TIMEOUT-th WAIT cycle; a done in that same cycle wins.
  assign tmo_hit    = (state == WAIT) & ~i_done & (tmo_cnt == TMO_W'(TIMEOUT - 1));

  dot_beat_packer #(
    .N            (N),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACT_WIDTH    (ACT_WIDTH),
    .LANES        (LANES)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (beat_fire),
    .clr          (early_last),
    .beat_w       (in_w),
    .beat_a       (in_a),
    .last_beat    (last_beat),
    .beat_done    (beat_done),
    .weights_flat (o_weights_flat),
    .acts_flat    (o_acts_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (beat_done)  state_nxt = FIRE;
      FIRE:                 state_nxt = WAIT;
      WAIT: begin
        if (i_done)         state_nxt = HOLD;
        else if (tmo_hit)   state_nxt = LOAD;
      end
      HOLD: if (res_ready)  state_nxt = LOAD;
      default:              state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    o_start   = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      LOAD:    in_ready  = 1'b1;
      FIRE:    o_start   = 1'b1;
      HOLD:    res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if ((state == WAIT) && i_done) begin
      res_data <= i_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (len_err)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
      if (tmo_hit)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_operand_loader.sv
module tb_dot_operand_loader;
  import dot_pkg::*;

  localparam int FW = N * ((WEIGHT_WIDTH > ACT_WIDTH) ? WEIGHT_WIDTH : ACT_WIDTH);

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [LANES*WEIGHT_WIDTH-1:0] in_w = '0;
  logic [LANES*ACT_WIDTH-1:0]    in_a = '0;
  logic                          in_last = 1'b0;
  logic                          o_start;
  logic [N*WEIGHT_WIDTH-1:0]     o_weights_flat;
  logic [N*ACT_WIDTH-1:0]        o_acts_flat;
  logic                          i_done = 1'b0;
  logic [RESULT_WIDTH-1:0]       i_result = '0;
  logic                          res_valid;
  logic                          res_ready = 1'b0;
  logic [RESULT_WIDTH-1:0]       res_data;
  logic                          err_len;
  logic                          err_timeout;
  logic                          err_clr = 1'b0;

  always #5 clk = ~clk;

  dot_operand_loader #(
    .N            (N),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACT_WIDTH    (ACT_WIDTH),
    .LANES        (LANES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_w           (in_w),
    .in_a           (in_a),
    .in_last        (in_last),
    .o_start        (o_start),
    .o_weights_flat (o_weights_flat),
    .o_acts_flat    (o_acts_flat),
    .i_done         (i_done),
    .i_result       (i_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .err_len        (err_len),
    .err_timeout    (err_timeout),
    .err_clr        (err_clr)
  );

  // Stimulus elements for the next frame, and the model of what the
  // engine-facing operand registers must hold (element values).
  int w_el [N];
  int a_el [N];
  int ew   [N];
  int ea   [N];

  logic                    exp_in_ready  = 1'b1;
  logic                    exp_start     = 1'b0;
  logic                    exp_res_valid = 1'b0;
  logic [RESULT_WIDTH-1:0] exp_res_data  = '0;
  logic                    exp_err_len   = 1'b0;
  logic                    exp_err_tmo   = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_wflat();
    logic [FW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = ew[i][WEIGHT_WIDTH-1:0];
    return v;
  endfunction

  function automatic logic [FW-1:0] model_aflat();
    logic [FW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*ACT_WIDTH +: ACT_WIDTH] = ea[i][ACT_WIDTH-1:0];
    return v;
  endfunction

  // Signed dot product of the modelled operands, truncated to 16 bits.
  function automatic logic [RESULT_WIDTH-1:0] model_dot();
    int s = 0;
    for (int i = 0; i < N; i++) s += ew[i] * ea[i];
    return s[RESULT_WIDTH-1:0];
  endfunction

  // Engine stand-in: computes from whatever the DUT presents.
  function automatic logic [RESULT_WIDTH-1:0] engine_dot();
    int s = 0;
    for (int i = 0; i < N; i++)
      s += int'($signed(o_weights_flat[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
         * int'($signed(o_acts_flat[i*ACT_WIDTH +: ACT_WIDTH]));
    return s[RESULT_WIDTH-1:0];
  endfunction

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(exp_in_ready));
    check("o_start", 32'(o_start), 32'(exp_start));
    check("res_valid", 32'(res_valid), 32'(exp_res_valid));
    check("res_data", 32'(res_data), 32'(exp_res_data));
    check("err_len", 32'(err_len), 32'(exp_err_len));
    check("err_timeout", 32'(err_timeout), 32'(exp_err_tmo));
    check_vec("o_weights_flat", FW'(o_weights_flat), model_wflat());
    check_vec("o_acts_flat", FW'(o_acts_flat), model_aflat());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int w, input int a);
    for (int i = 0; i < N; i++) begin
      w_el[i] = w;
      a_el[i] = a;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      ew[i] = 0;
      ea[i] = 0;
    end
  endtask

  // Drive a frame; in_last on beat last_at (-1: never). gap inserts idle
  // cycles (in_valid=0, junk data, in_last=1) that must not count as beats.
  // Returns in the FIRE cycle, or right after an aborted beat.
  task automatic send_frame(input int last_at, input bit gap);
    for (int k = 0; k < BEATS; k++) begin
      bit err_ev;
      if (gap && (k % 5) == 2) begin
        in_valid = 1'b0; in_last = 1'b1; in_w = $urandom; in_a = $urandom;
        cyc();
        if (err_clr) begin exp_err_len = 1'b0; exp_err_tmo = 1'b0; end
      end
      in_valid = 1'b1;
      in_last  = (k == last_at);
      for (int j = 0; j < LANES; j++) begin
        in_w[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_el[k*LANES+j][WEIGHT_WIDTH-1:0];
        in_a[j*ACT_WIDTH +: ACT_WIDTH]       = a_el[k*LANES+j][ACT_WIDTH-1:0];
      end
      cyc();
      for (int j = 0; j < LANES; j++) begin
        ew[k*LANES+j] = w_el[k*LANES+j];
        ea[k*LANES+j] = a_el[k*LANES+j];
      end
      err_ev = (in_last && k < BEATS-1) || (!in_last && k == BEATS-1);
      if (err_ev) exp_err_len = 1'b1;
      else if (err_clr) exp_err_len = 1'b0;
      if (err_clr) exp_err_tmo = 1'b0;
      if (in_last && k < BEATS-1) begin
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    exp_in_ready = 1'b0;
    exp_start = 1'b1;
  endtask

  // From the FIRE cycle: engine answers in WAIT cycle lat, or never.
  // Junk beats are offered throughout WAIT and must be ignored.
  task automatic run_engine(input int lat, input bit respond);
    cyc();
    exp_start = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      in_valid = 1'b1; in_w = $urandom; in_a = $urandom; in_last = 1'($urandom_range(0, 1));
      i_result = 16'($urandom);
      if (respond && c == lat) begin
        i_done = 1'b1;
        i_result = engine_dot();
        cyc();
        i_done = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        exp_res_valid = 1'b1;
        exp_res_data = model_dot();
        return;
      end
      if (c == TIMEOUT) begin
        in_valid = 1'b0; in_last = 1'b0;
        cyc();
        exp_err_tmo = 1'b1;
        exp_in_ready = 1'b1;
        return;
      end
      cyc();
    end
  endtask

  // From the first HOLD cycle: stall hold cycles, then complete the handshake.
  task automatic accept_result(input int hold);
    res_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1; in_w = $urandom; in_a = $urandom;
      i_done = 1'b1; i_result = 16'($urandom);
      cyc();
    end
    i_done = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    exp_res_valid = 1'b0;
    exp_in_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    model_zero();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // i_done while loading is ignored
    i_done = 1'b1; i_result = 16'h1234;
    cyc();
    i_done = 1'b0;
    cyc();

    // ones vector
    set_all(1, 1);
    send_frame(BEATS-1, 1'b0);
    check("model_ones", 32'(model_dot()), 32'h0080);
    run_engine(5, 1'b1);
    check("res_ones", 32'(res_data), 32'h0080);
    accept_result(0);

    // extreme values
    set_all(7, -8);
    send_frame(BEATS-1, 1'b0);
    run_engine(5, 1'b1);
    check("res_extreme", 32'(res_data), 32'hE400);
    check_vec("w_all7", FW'(o_weights_flat), FW'({N{4'h7}}));
    accept_result(0);

    // mixed pattern with bubbles, no in_last, backpressured result
    for (int i = 0; i < N; i++) begin
      w_el[i] = ((i * 3) % 16) - 8;
      a_el[i] = 7 - ((i * 5) % 16);
    end
    send_frame(-1, 1'b1);
    run_engine(3, 1'b1);
    accept_result(10);
    check("in_ready_after_hs", 32'(in_ready), 32'h1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    exp_err_tmo = 1'b0;

    // early in_last on beat 3 while err_clr is held: the set wins
    set_all(-3, 5);
    err_clr = 1'b1;
    send_frame(3, 1'b0);
    err_clr = 1'b0;
    check("err_len_early", 32'(err_len), 32'h1);
    repeat (3) cyc();
    set_all(1, 1);
    send_frame(BEATS-1, 1'b0);
    run_engine(5, 1'b1);
    check("res_after_abort", 32'(res_data), 32'h0080);
    accept_result(0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    exp_err_len = 1'b0;
    exp_err_tmo = 1'b0;

    // engine timeout
    set_all(-1, 2);
    send_frame(BEATS-1, 1'b0);
    run_engine(0, 1'b0);
    check("err_timeout_set", 32'(err_timeout), 32'h1);
    repeat (3) cyc();

    // asynchronous reset two cycles into WAIT, with a late engine done
    set_all(2, 3);
    send_frame(BEATS-1, 1'b0);
    cyc();
    exp_start = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    model_zero();
    exp_in_ready = 1'b1; exp_res_valid = 1'b0; exp_res_data = '0;
    exp_err_len = 1'b0; exp_err_tmo = 1'b0;
    #1;
    check("rst_o_start", 32'(o_start), 32'h0);
    check("rst_err_timeout", 32'(err_timeout), 32'h0);
    check_vec("rst_weights", FW'(o_weights_flat), '0);
    check_vec("rst_acts", FW'(o_acts_flat), '0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    i_done = 1'b1; i_result = 16'h5555;
    cyc();
    i_done = 1'b0;
    repeat (4) cyc();
    check("late_done_ignored", 32'(res_valid), 32'h0);

    // normal operation after reset
    set_all(1, 1);
    send_frame(BEATS-1, 1'b0);
    run_engine(5, 1'b1);
    check("res_post_reset", 32'(res_data), 32'h0080);
    accept_result(2);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
